uart_rx_param: RTL

Parametrised UART receive engine: the next-generation receiver, generalised in divisor, oversampling ratio, word length and parity mode, with a valid/ready output handshake and error reporting. It sits between the pad-side UART_RX line and the control logic, in the same single sysclk domain. Unlike the fixed 8N1 receiver it adds:
- input synchronisation;
- false-start rejection;
- parity/framing checks;
- overrun detection.

---
 rtl/uart_rx_param.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with a valid/ready output,
//            parity/framing error flags and overrun detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DIVISOR    = 326,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int TICK_W = $clog2(DIVISOR);
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVISOR - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic sync_q;
    logic rx_s;
    logic rx_d;

    logic [TICK_W-1:0]    tick_cnt;
    logic [SAMP_W-1:0]    samp_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 par_err_q;

    logic tick;
    logic at_mid;
    logic at_centre;
    logic fall;
    logic clr_samp;
    logic shift_en;
    logic par_smp;
    logic done;
    logic accept;

    // Synchroniser plus one extra stage for falling-edge detection on rx_s.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= UART_RX;
            rx_s   <= sync_q;
            rx_d   <= rx_s;
        end
    end

    assign fall      = rx_d & ~rx_s;
    assign tick      = (state != S_IDLE) && (tick_cnt == TICK_LAST);
    assign at_mid    = tick && (samp_cnt == SAMP_MID);
    assign at_centre = tick && (samp_cnt == SAMP_LAST);
    assign accept    = RX_VALID & RX_READY;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_samp   = 1'b0;
        shift_en   = 1'b0;
        par_smp    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (at_mid) begin
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DATA;
                        clr_samp   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (at_centre) begin
                    shift_en = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (at_centre) begin
                    par_smp    = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leave mid stop bit so an immediately following start is seen.
                if (at_centre) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
            bit_idx  <= '0;
        end else if ((state == S_IDLE) || (state_next == S_IDLE)) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (clr_samp) begin
                samp_cnt <= '0;
            end else if (tick) begin
                samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
            end
            if (shift_en) begin
                bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
        end else if (state == S_IDLE) begin
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                par_acc <= par_acc ^ rx_s;
            end
            if (par_smp) begin
                // Odd parity wants the overall XOR to be 1, even wants 0.
                par_err_q <= (PARITY == 1) ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            OVERRUN <= 1'b0;
            if (done) begin
                if (!RX_VALID || RX_READY) begin
                    RX_DATA    <= shreg;
                    PARITY_ERR <= (PARITY != 0) ? par_err_q : 1'b0;
                    FRAME_ERR  <= ~rx_s;
                    RX_VALID   <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (accept) begin
                RX_VALID <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
